led_trail_pwm: RTL and testbench

//   Downstream stage of the rotating 16-LED light. Consumes its one-hot led[15:0] pattern and drives the board LEDs.

---
 rtl/led_trail_pwm.sv | 69 ++++++
 tb/tb_led_trail_pwm.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/led_trail_pwm.sv
// Trail/PWM output stage for the rotating 16-LED light.
// Lit LEDs jump to full brightness, then fade out linearly via per-LED PWM.
module led_trail_pwm #(
    parameter int PWM_BITS   = 8,
    parameter int DECAY_DIV  = 250000,
    parameter int DECAY_STEP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trail_en,
    input  logic [15:0] led_in,
    output logic [15:0] led_out,
    output logic        decay_tk
);

    localparam int DW = $clog2(DECAY_DIV);
    localparam logic [PWM_BITS-1:0] MAX  = '1;
    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);
    localparam logic [DW-1:0] DEC_LAST   = DW'(DECAY_DIV - 1);

    logic [15:0]         led_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DW-1:0]       dec_cnt;
    logic [PWM_BITS-1:0] level     [16];
    logic [PWM_BITS-1:0] level_nxt [16];
    logic [15:0]         out_nxt;
    logic                decay_now;

    assign decay_now = (dec_cnt == DEC_LAST);

    // Refresh outranks decay; decay saturates at zero.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            level_nxt[i] = level[i];
            if (!trail_en) begin
                level_nxt[i] = '0;
            end else if (led_q[i]) begin
                level_nxt[i] = MAX;
            end else if (decay_now) begin
                level_nxt[i] = (level[i] >= STEP) ? level[i] - STEP : '0;
            end
            out_nxt[i] = trail_en ? ((level[i] == MAX) || (level[i] > pwm_cnt))
                                  : led_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q    <= '0;
            pwm_cnt  <= '0;
            dec_cnt  <= '0;
            led_out  <= '0;
            decay_tk <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                level[i] <= '0;
            end
        end else begin
            led_q    <= led_in;
            pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
            dec_cnt  <= decay_now ? '0 : dec_cnt + DW'(1);
            decay_tk <= decay_now;
            led_out  <= out_nxt;
            for (int i = 0; i < 16; i++) begin
                level[i] <= level_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm: per-cycle reference model feeding a scoreboard,
// plus directed vectors with hand-derived expectations.
module tb_led_trail_pwm;

    localparam int PB   = 4;
    localparam int DIV  = 4;
    localparam int STP  = 4;
    localparam int MAXV = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        trail_en;
    logic [15:0] led_in;
    logic [15:0] led_out;
    logic        decay_tk;

    int tests = 0;
    int fails = 0;
    int edge_n = 0;

    led_trail_pwm #(
        .PWM_BITS  (PB),
        .DECAY_DIV (DIV),
        .DECAY_STEP(STP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .trail_en(trail_en),
        .led_in  (led_in),
        .led_out (led_out),
        .decay_tk(decay_tk)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Edges since the last reset release; DUT counters share this phase.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    // Reference model: pushes the expected outputs after every edge.
    logic [16:0] exp_q[$];
    logic [15:0] m_q;
    logic [15:0] m_out;
    int          m_lvl[16];
    int          m_pwm;
    int          m_dec;
    bit          m_step;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q   = '0;
            m_pwm = 0;
            m_dec = 0;
            for (int i = 0; i < 16; i++) m_lvl[i] = 0;
            exp_q.delete();
            exp_q.push_back(17'h0);
        end else begin
            m_step = (m_dec == DIV - 1);
            for (int i = 0; i < 16; i++) begin
                if (trail_en)
                    m_out[i] = (m_lvl[i] == MAXV) || (m_lvl[i] > m_pwm);
                else
                    m_out[i] = m_q[i];
                if (!trail_en)      m_lvl[i] = 0;
                else if (m_q[i])    m_lvl[i] = MAXV;
                else if (m_step)    m_lvl[i] = (m_lvl[i] >= STP) ? m_lvl[i] - STP : 0;
            end
            m_q   = led_in;
            m_pwm = (m_pwm + 1) % (MAXV + 1);
            m_dec = m_step ? 0 : m_dec + 1;
            exp_q.push_back({m_out, m_step});
        end
    end

    // Scoreboard monitor.
    logic [16:0] sb_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front();
            check("sb_led_out", 32'(led_out), 32'(sb_e[16:1]));
            check("sb_decay_tk", 32'(decay_tk), 32'(sb_e[0]));
        end
    end

    task automatic at_neg(input int k);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (edge_n != k && g < 500);
        if (edge_n != k) begin
            tests++;
            fails++;
            $display("FAIL at_neg_timeout: got edge %0d expected %0d", edge_n, k);
        end
    endtask

    // Called from a negedge; asserts rst mid-cycle and returns at N0.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_led_out", 32'(led_out), 32'h0);
        check("rst_decay_tk", 32'(decay_tk), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        trail_en = 1'b0;
        led_in   = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Prescaler phase and pass-through latency.
        for (int k = 1; k <= 24; k++) begin
            at_neg(k);
            check("decay_tk_phase", 32'(decay_tk), 32'((k % 4) == 0));
            check("pass_through", 32'(led_out),
                  (k == 4 || k == 5) ? 32'hA5A5 : 32'h0);
            if (k == 2) led_in = 16'hA5A5;
            if (k == 4) led_in = '0;
            if (k == 8) trail_en = 1'b1;
        end

        // Fade of LED 0: levels 15,15,11x4,7x4,3x4,0 against pwm 0..15.
        do_reset();
        led_in = 16'h0001;
        for (int k = 1; k <= 40; k++) begin
            at_neg(k);
            if (k == 1) led_in = '0;
            check("fade", 32'(led_out), (k >= 3 && k <= 8) ? 32'h1 : 32'h0);
        end

        // Refresh colliding with decay at edge 12, then steady full-on.
        do_reset();
        for (int k = 1; k <= 45; k++) begin
            at_neg(k);
            if (k >= 11 && k <= 16)
                check("collision", 32'(led_out), (k >= 12) ? 32'h8 : 32'h0);
            if (k >= 23)
                check("full_on", 32'(led_out), (k >= 25) ? 32'h1 : 32'h0);
            if (k == 9)  led_in = 16'h0008;
            if (k == 11) led_in = '0;
            if (k == 20) trail_en = 1'b0;
            if (k == 22) begin
                trail_en = 1'b1;
                led_in   = 16'h0001;
            end
        end

        // Rotation, reset mid-fade while decay_tk is high, then recovery.
        for (int s = 0; s < 18; s++) begin
            led_in = 16'h0001 << (s % 16);
            repeat (8) @(negedge clk);
        end
        for (int g = 0; g < 4 && (edge_n % 4) != 0; g++) @(negedge clk);
        check("tk_before_rst", 32'(decay_tk), 32'h1);
        do_reset();
        for (int s = 0; s < 10; s++) begin
            led_in = 16'h0001 << ((s + 5) % 16);
            repeat (8) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
